// File: rtl/beep_pkg.sv
// rtl/beep_pkg.sv - shared state encoding, code width and unit-length helper for beep_sched
package beep_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} beep_state_e;

  localparam int CODE_W = 3;

  function automatic int unit_cyc(input int clk_freq, input int unit_ms);
    return clk_freq / 1000 * unit_ms;
  endfunction

endpackage

// File: rtl/beep_unit_timer.sv
// rtl/beep_unit_timer.sv - clearable up-counter flagging the last cycle of one unit and of a double-unit gap
module beep_unit_timer #(
  parameter int UNIT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  output logic o_tc_unit,
  output logic o_tc_gap
);

  localparam int TW = $clog2(2 * UNIT_CYC);
  localparam logic [TW-1:0] TC_UNIT = TW'(UNIT_CYC - 1);
  localparam logic [TW-1:0] TC_GAP  = TW'(2 * UNIT_CYC - 1);

  logic [TW-1:0] r_timer;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_timer <= '0;
    end else if (i_clr) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign o_tc_unit = (r_timer == TC_UNIT);
  assign o_tc_gap  = (r_timer == TC_GAP);

endmodule

// File: rtl/beep_sched.sv
// rtl/beep_sched.sv - fixed-priority beep request arbiter and buzzer pattern sequencer
// BEEP_TONE_PWM_EN: beep becomes a TONE_DIV square wave during ON for a passive buzzer.
module beep_sched
  import beep_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UNIT_MS  = 200,
  parameter int N_REQ    = 3,
  parameter int TONE_DIV = 12_500
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req,
  input  logic [CODE_W*N_REQ-1:0]  code,
  output logic [N_REQ-1:0]         ack,
  output logic                     busy,
  output logic                     beep
);

  localparam int UNIT_CYC = unit_cyc(CLK_FREQ, UNIT_MS);

  beep_state_e                   r_state;
  logic [N_REQ-1:0]              r_pend;
  logic [N_REQ-1:0][CODE_W-1:0]  r_code;
  logic [N_REQ-1:0]              r_ack;
  logic [CODE_W-1:0]             r_cnt;
  logic                          r_busy;
  logic                          r_beep;

  logic [N_REQ-1:0]              w_set;
  logic [N_REQ-1:0]              w_gnt;
  logic [CODE_W-1:0]             w_gnt_code;
  logic [CODE_W-1:0]             w_cnt_dec;
  logic                          w_grant;
  logic                          w_tmr_clr;
  logic                          w_tc_unit;
  logic                          w_tc_gap;

`ifdef BEEP_TONE_PWM_EN
  localparam int DIV_W = $clog2(TONE_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TONE_DIV - 1);
  logic [DIV_W-1:0] r_div;
`endif

  always_comb begin
    w_set = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_set[i] = req[i] && (code[CODE_W*i +: CODE_W] != '0);
    end
  end

  // Isolating the lowest set pend bit gives index-0-first priority.
  assign w_gnt   = r_pend & (~r_pend + 1'b1);
  assign w_grant = (r_state == IDLE) && (|r_pend);

  always_comb begin
    w_gnt_code = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) w_gnt_code = w_gnt_code | r_code[i];
    end
  end

  // A fresh request beats a same-cycle grant clear; the grant uses the old code.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= '0;
      r_code <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_set[i]) begin
          r_pend[i] <= 1'b1;
          r_code[i] <= code[CODE_W*i +: CODE_W];
        end else if (w_grant && w_gnt[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  assign w_tmr_clr = (r_state == IDLE)
                   || (((r_state == ON) || (r_state == OFF)) && w_tc_unit)
                   || ((r_state == GAP) && w_tc_gap);

  beep_unit_timer #(
    .UNIT_CYC (UNIT_CYC)
  ) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .i_clr     (w_tmr_clr),
    .o_tc_unit (w_tc_unit),
    .o_tc_gap  (w_tc_gap)
  );

  assign w_cnt_dec = r_cnt - 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_ack   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_beep  <= 1'b0;
`ifdef BEEP_TONE_PWM_EN
      r_div   <= '0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_ack   <= w_gnt;
            r_cnt   <= w_gnt_code;
            r_state <= ON;
            r_busy  <= 1'b1;
            r_beep  <= 1'b1;
`ifdef BEEP_TONE_PWM_EN
            r_div   <= '0;
`endif
          end
        end
        ON: begin
          if (w_tc_unit) begin
            r_cnt   <= w_cnt_dec;
            r_beep  <= 1'b0;
            r_state <= (w_cnt_dec != '0) ? OFF : GAP;
          end else begin
`ifdef BEEP_TONE_PWM_EN
            if (r_div == DIV_LAST) begin
              r_div  <= '0;
              r_beep <= ~r_beep;
            end else begin
              r_div  <= r_div + 1'b1;
            end
`endif
          end
        end
        OFF: begin
          if (w_tc_unit) begin
            r_state <= ON;
            r_beep  <= 1'b1;
`ifdef BEEP_TONE_PWM_EN
            r_div   <= '0;
`endif
          end
        end
        GAP: begin
          if (w_tc_gap) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ack  = r_ack;
  assign busy = r_busy;
  assign beep = r_beep;

endmodule

// File: tb/tb_beep_sched.sv
// tb/tb_beep_sched.sv - table-driven and sequence checks for beep_sched with UNIT_CYC=5
module tb_beep_sched;

  localparam int U = 5;

  logic       clk;
  logic       rstn;
  logic [2:0] req;
  logic [8:0] code;
  logic [2:0] ack;
  logic       busy;
  logic       beep;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [2:0] req;
    logic [8:0] code;
    logic [2:0] exp_ack;
    int         n;
  } vec_t;

  vec_t vecs [5];

  beep_sched #(
    .CLK_FREQ (1000),
    .UNIT_MS  (5),
    .N_REQ    (3),
    .TONE_DIV (1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .req  (req),
    .code (code),
    .ack  (ack),
    .busy (busy),
    .beep (beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Entered at the negedge right after the grant edge; leaves at the first IDLE negedge.
  task automatic play_check(input logic [2:0] exp_ack, input int n,
                            input int k0, input logic [2:0] r0, input logic [8:0] c0,
                            input int k1, input logic [2:0] r1, input logic [8:0] c1);
    int   total;
    int   w;
    logic eb;
    total = (2 * n + 1) * U;
    for (int k = 0; k < total; k++) begin
      w  = k / U;
      eb = (w < 2 * n - 1) && (w % 2 == 0);
`ifdef BEEP_TONE_PWM_EN
      if (eb) eb = ((k % U) % 2 == 0);
`endif
      chk("ack_pattern", ack, (k == 0) ? exp_ack : 3'b000);
      chk("busy_pattern", busy, 1'b1);
      chk("beep_pattern", beep, eb);
      req  = '0;
      code = '0;
      if (k == k0) begin req = r0; code = c0; end
      if (k == k1) begin req = r1; code = c1; end
      @(negedge clk);
    end
    req  = '0;
    code = '0;
    chk("ack_idle", ack, 3'b000);
    chk("busy_idle", busy, 1'b0);
    chk("beep_idle", beep, 1'b0);
  endtask

  // Drive a request at the current negedge and check the pend-only cycle.
  task automatic issue(input logic [2:0] r, input logic [8:0] c);
    req  = r;
    code = c;
    @(negedge clk);
    req  = '0;
    code = '0;
    chk("ack_pend_cycle", ack, 3'b000);
    chk("busy_pend_cycle", busy, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{3'b010, {3'd0, 3'd3, 3'd0}, 3'b010, 3};
    vecs[1] = '{3'b001, {3'd0, 3'd0, 3'd7}, 3'b001, 7};
    vecs[2] = '{3'b100, {3'd1, 3'd0, 3'd0}, 3'b100, 1};
    vecs[3] = '{3'b010, {3'd0, 3'd0, 3'd0}, 3'b000, 0};
    vecs[4] = '{3'b011, {3'd0, 3'd2, 3'd0}, 3'b010, 2};

    rstn = 1'b0;
    req  = '0;
    code = '0;
    repeat (3) @(negedge clk);
    chk("reset_ack", ack, 3'b000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_beep", beep, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      issue(vecs[v].req, vecs[v].code);
      if (vecs[v].n == 0) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("zero_code_ack", ack, 3'b000);
          chk("zero_code_busy", busy, 1'b0);
          chk("zero_code_beep", beep, 1'b0);
        end
      end else begin
        @(negedge clk);
        play_check(vecs[v].exp_ack, vecs[v].n, -1, '0, '0, -1, '0, '0);
      end
    end

    // Simultaneous requests: index 0 first, index 2 on the first IDLE cycle.
    issue(3'b101, {3'd1, 3'd0, 3'd2});
    @(negedge clk);
    play_check(3'b001, 2, -1, '0, '0, -1, '0, '0);
    @(negedge clk);
    play_check(3'b100, 1, -1, '0, '0, -1, '0, '0);

    // Higher index arriving mid-pattern waits for the gap to finish.
    issue(3'b001, {3'd0, 3'd0, 3'd3});
    @(negedge clk);
    play_check(3'b001, 3, 3, 3'b100, {3'd4, 3'd0, 3'd0}, -1, '0, '0);
    @(negedge clk);
    play_check(3'b100, 4, -1, '0, '0, -1, '0, '0);

    // Repeat request while pending: latest code is played.
    issue(3'b001, {3'd0, 3'd0, 3'd1});
    @(negedge clk);
    play_check(3'b001, 1, 1, 3'b010, {3'd0, 3'd2, 3'd0}, 4, 3'b010, {3'd0, 3'd5, 3'd0});
    @(negedge clk);
    play_check(3'b010, 5, -1, '0, '0, -1, '0, '0);

    // Reset during ON with another request pending.
    issue(3'b010, {3'd0, 3'd3, 3'd0});
    @(negedge clk);
    chk("rst_seq_ack", ack, 3'b010);
    chk("rst_seq_beep_on", beep, 1'b1);
    req  = 3'b001;
    code = {3'd0, 3'd0, 3'd2};
    @(negedge clk);
    req  = '0;
    code = '0;
    @(negedge clk);
    chk("rst_seq_beep_before", beep, 1'b1);
    rstn = 1'b0;
    #1;
    chk("rst_async_beep", beep, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_ack", ack, 3'b000);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("post_rst_ack", ack, 3'b000);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_beep", beep, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
